// File: rtl/difftest_trap_arbiter.sv
// Round-robin funnel of per-core trap/WFI snapshots onto one difftest trap-event sink.
// Optional idle watchdog: define DIFFTEST_TRAP_WATCHDOG_EN.
module difftest_trap_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_ID_BASE   = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CORES-1:0]   in_valid,
    output logic [NUM_CORES-1:0]   in_ready,
    input  logic [NUM_CORES-1:0]   in_hasTrap,
    input  logic [NUM_CORES-1:0]   in_hasWFI,
    input  logic [64*NUM_CORES-1:0] in_cycleCnt,
    input  logic [64*NUM_CORES-1:0] in_instrCnt,
    input  logic [32*NUM_CORES-1:0] in_code,
    input  logic [64*NUM_CORES-1:0] in_pc,
    output logic                   out_enable,
    output logic                   out_hasTrap,
    output logic                   out_hasWFI,
    output logic [63:0]            out_cycleCnt,
    output logic [63:0]            out_instrCnt,
    output logic [31:0]            out_code,
    output logic [63:0]            out_pc,
    output logic [7:0]             out_coreid,
    output logic                   trap_seen,
    output logic [7:0]             trap_coreid,
    output logic                   timeout
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    if (NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("difftest_trap_arbiter: NUM_CORES must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic        has_trap;
        logic        has_wfi;
        logic [63:0] cycle_cnt;
        logic [63:0] instr_cnt;
        logic [31:0] code;
        logic [63:0] pc;
    } event_t;

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int step);
        return IDX_W'((base + step) % NUM_CORES);
    endfunction

    event_t               in_ev [NUM_CORES];
    event_t               slot_p0 [NUM_CORES];
    logic [NUM_CORES-1:0] vld_p0;
    logic [NUM_CORES-1:0] grant;
    logic [NUM_CORES-1:0] accept;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    event_t               out_ev_p1;
    logic [7:0]           coreid_p1;
    logic                 vld_p1;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            in_ev[i].has_trap  = in_hasTrap[i];
            in_ev[i].has_wfi   = in_hasWFI[i];
            in_ev[i].cycle_cnt = in_cycleCnt[64*i +: 64];
            in_ev[i].instr_cnt = in_instrCnt[64*i +: 64];
            in_ev[i].code      = in_code[32*i +: 32];
            in_ev[i].pc        = in_pc[64*i +: 64];
        end
    end

    // First full slot at or after the round-robin pointer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_any && vld_p0[wrap_idx(int'(rr_ptr), k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(int'(rr_ptr), k);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // A granted slot empties this cycle, so it can refill in the same edge.
    assign in_ready = ~vld_p0 | grant;
    assign accept   = in_valid & in_ready;

    // ---- stage p0: per-core holding slots ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0 <= '0;
        end else begin
            vld_p0 <= accept | (vld_p0 & ~grant);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accept[i]) slot_p0[i] <= in_ev[i];
        end
    end

    // ---- stage p1: registered output bundle and trap bookkeeping ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            out_ev_p1   <= '0;
            coreid_p1   <= '0;
            rr_ptr      <= '0;
            trap_seen   <= 1'b0;
            trap_coreid <= '0;
        end else begin
            vld_p1 <= grant_any;
            if (grant_any) begin
                out_ev_p1 <= slot_p0[grant_idx];
                coreid_p1 <= 8'(CORE_ID_BASE + int'(grant_idx));
                rr_ptr    <= wrap_idx(int'(grant_idx), 1);
            end
            if (vld_p1 && out_ev_p1.has_trap && !trap_seen) begin
                trap_seen   <= 1'b1;
                trap_coreid <= coreid_p1;
            end
        end
    end

    assign out_enable   = vld_p1;
    assign out_hasTrap  = out_ev_p1.has_trap;
    assign out_hasWFI   = out_ev_p1.has_wfi;
    assign out_cycleCnt = out_ev_p1.cycle_cnt;
    assign out_instrCnt = out_ev_p1.instr_cnt;
    assign out_code     = out_ev_p1.code;
    assign out_pc       = out_ev_p1.pc;
    assign out_coreid   = coreid_p1;

`ifdef DIFFTEST_TRAP_WATCHDOG_EN
    logic [31:0] idle_cnt;
    logic        timeout_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (vld_p1) begin
                idle_cnt <= '0;
            end else if (idle_cnt != 32'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
            if (idle_cnt == 32'(TIMEOUT_CYCLES)) timeout_r <= 1'b1;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/difftest_trap_arbiter.md
Name: difftest_trap_arbiter

Overview:
- Shares a single trap-event reporting channel between NUM_CORES cores.
- Each core posts trap/WFI/instruction-count snapshots through a valid/ready handshake into a one-entry holding slot.
- A round-robin arbiter drains one slot per cycle into a registered output bundle that drives the downstream difftest trap-event sink (its enable plus payload).
- Also records the first core to report a trap, for harness termination logic.

Parameters:
- NUM_CORES, 4, number of requesting cores (1..8)
- CORE_ID_BASE, 0, coreid reported for core index 0; index i reports CORE_ID_BASE+i, truncated to 8 bits
- TIMEOUT_CYCLES, 1000000, watchdog limit; used only with the optional feature

Ports:
- clock  in  1  single clock, posedge
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_CORES  per-core event request
- in_ready  out  NUM_CORES  per-core slot can accept
- in_hasTrap  in  NUM_CORES  per-core trap flag
- in_hasWFI  in  NUM_CORES  per-core WFI flag
- in_cycleCnt  in  64*NUM_CORES  packed, core i at [64i+63:64i]
- in_instrCnt  in  64*NUM_CORES  packed as above
- in_code  in  32*NUM_CORES  packed, core i at [32i+31:32i]
- in_pc  in  64*NUM_CORES  packed as above
- out_enable  out  1  one-cycle pulse, payload valid
- out_hasTrap  out  1  granted payload
- out_hasWFI  out  1  granted payload
- out_cycleCnt  out  64  granted payload
- out_instrCnt  out  64  granted payload
- out_code  out  32  granted payload
- out_pc  out  64  granted payload
- out_coreid  out  8  CORE_ID_BASE + granted index
- trap_seen  out  1  sticky: a trap event has been emitted
- trap_coreid  out  8  coreid of first emitted trap
- timeout  out  1  watchdog flag (0 when feature absent)

Behaviour:
- Reset: slots empty, rr pointer = 0, all outputs 0, trap_seen = 0, trap_coreid = 0; in_ready = all ones on the first cycle after reset.
- Slot i holds {hasTrap, hasWFI, cycleCnt, instrCnt, code, pc} plus a full bit.
- in_ready[i] = !full[i] | grant[i] (combinational). Handshake completes when in_valid[i] & in_ready[i]; payload is captured at that edge.
- Grant is combinational, one-hot over full bits. Search starts at rr pointer, ascending, wrapping modulo NUM_CORES. After granting i, pointer = (i+1) mod NUM_CORES; with no grant, pointer holds.
- On grant at cycle t, the out_* payload registers load at the end of t, so out_enable = 1 during t+1. Without a grant, out_enable = 0 and the payload holds its last value.
- Latency: accept at edge e gives full at e, grant in the following cycle, and out_enable one cycle after that (2 cycles minimum). Throughput is 1 event/cycle aggregate; a single core streams at 1/cycle via simultaneous grant and accept.
- Simultaneous accept and grant on the same slot: the old entry is emitted, the new entry is loaded, and full stays 1.
- Accept on a slot that is full and not granted is impossible (in_ready = 0); the core must hold in_valid and payload.
- trap_seen sets when out_enable & out_hasTrap; trap_coreid loads out_coreid only on the 0→1 transition of trap_seen. Later traps do not change it. Arbitration continues after a trap.
- Synchronous reset mid-operation discards all slot contents and any pending output; nothing is emitted in the cycle after reset.
- NUM_CORES = 1: pointer is constant 0; same timing rules apply.

Optional Feature:
- Macro: DIFFTEST_TRAP_WATCHDOG_EN
- With the macro defined:
  - A 32-bit counter increments every cycle while out_enable = 0 and clears on any out_enable.
  - When it equals TIMEOUT_CYCLES, timeout sets and stays sticky until reset; the counter saturates.
- Without the macro: no counter is built, timeout is tied to 0, and the parameter is ignored.

Test Plan:
- Reset, then core 2 posts pc=0x80000000, code=0, hasTrap=1 → exactly two cycles later out_enable=1 with out_coreid=2, out_pc=0x80000000; trap_seen=1 and trap_coreid=2 on the next cycle.
- All 4 cores assert valid in the same cycle → out_enable for 4 consecutive cycles with coreids 0,1,2,3; then all 4 again → order 0,1,2,3 (pointer wrapped to 0).
- Core 1 holds in_valid for 6 cycles with cycleCnt 10..15, others idle → in_ready stays 1; outputs carry cycleCnt 10..15 on 6 consecutive cycles.
- Cores 0 and 3 both trap in the same cycle → first emitted is coreid 0; trap_coreid=0 and stays 0 after core 3's trap is emitted.
- Reset asserted for 1 cycle while 3 slots are full → no out_enable afterwards, in_ready = all ones, trap_seen=0.
- With DIFFTEST_TRAP_WATCHDOG_EN and TIMEOUT_CYCLES=16, no traffic → timeout rises after 16 idle cycles and stays high after a later event; without the macro, timeout stays 0.
